// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_TAG_W  = 2;

  // tag is {err_stop, err_rx}, matching the AXIS tuser ordering
  typedef struct packed {
    logic [UART_TAG_W-1:0]  tag;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_addr_i] = wr_data_i;
    end
  end

  // Storage carries no reset; the top masks the head output while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with level/status and sticky overflow.
// Define UART_RX_FIFO_ERR_TAG_EN to store {err_stop, err_rx} with each byte and present it on tuser.
module axis_uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] saxis_data_i,
  input  logic                   saxis_tvalid_i,
  output logic                   saxis_tready_o,
  input  logic                   err_rx_i,
  input  logic                   err_stop_i,
  input  logic                   err_rx_dropped_i,
  output logic [UART_DATA_W-1:0] maxis_data_o,
  output logic [UART_TAG_W-1:0]  maxis_tuser_o,
  output logic                   maxis_tvalid_o,
  input  logic                   maxis_tready_i,
  input  logic                   flush_i,
  input  logic [LVL_W-1:0]       af_thr_i,
  output logic [LVL_W-1:0]       level_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   overflow_o,
  input  logic                   overflow_clr_i
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int ENTRY_W = $bits(rx_entry_t);
`else
  localparam int ENTRY_W = UART_DATA_W;
`endif
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               dropped_q, dropped_d;
  logic               full, empty, push, pop, wr_en;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign push  = saxis_tvalid_i && !full;
  assign pop   = !empty && maxis_tready_i;
  assign wr_en = push && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // A fresh rise of the dropped-byte level beats a coincident clear.
  always_comb begin
    dropped_d  = err_rx_dropped_i;
    overflow_d = overflow_q;
    if (err_rx_dropped_i && !dropped_q) begin
      overflow_d = 1'b1;
    end else if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

`ifdef UART_RX_FIFO_ERR_TAG_EN
  rx_entry_t head;
  assign wr_entry      = {err_stop_i, err_rx_i, saxis_data_i};
  assign head          = rx_entry_t'(rd_entry);
  assign maxis_data_o  = empty ? '0 : head.data;
  assign maxis_tuser_o = empty ? '0 : head.tag;
`else
  logic unused_err;
  assign unused_err    = err_rx_i ^ err_stop_i;
  assign wr_entry      = saxis_data_i;
  assign maxis_data_o  = empty ? '0 : rd_entry;
  assign maxis_tuser_o = '0;
`endif

  assign saxis_tready_o = !full;
  assign maxis_tvalid_o = !empty;
  assign level_o        = level_q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_full_o  = (level_q >= af_thr_i);
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// Scoreboard bench for axis_uart_rx_fifo: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_axis_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       saxis_data_i = '0;
  logic             saxis_tvalid_i = 1'b0;
  logic             saxis_tready_o;
  logic             err_rx_i = 1'b0;
  logic             err_stop_i = 1'b0;
  logic             err_rx_dropped_i = 1'b0;
  logic [7:0]       maxis_data_o;
  logic [1:0]       maxis_tuser_o;
  logic             maxis_tvalid_o;
  logic             maxis_tready_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [LVL_W-1:0] af_thr_i = LVL_W'(12);
  logic [LVL_W-1:0] level_o;
  logic             empty_o, full_o, almost_full_o, overflow_o;
  logic             overflow_clr_i = 1'b0;

  always #5 clk = ~clk;

  axis_uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .saxis_data_i     (saxis_data_i),
    .saxis_tvalid_i   (saxis_tvalid_i),
    .saxis_tready_o   (saxis_tready_o),
    .err_rx_i         (err_rx_i),
    .err_stop_i       (err_stop_i),
    .err_rx_dropped_i (err_rx_dropped_i),
    .maxis_data_o     (maxis_data_o),
    .maxis_tuser_o    (maxis_tuser_o),
    .maxis_tvalid_o   (maxis_tvalid_o),
    .maxis_tready_i   (maxis_tready_i),
    .flush_i          (flush_i),
    .af_thr_i         (af_thr_i),
    .level_o          (level_o),
    .empty_o          (empty_o),
    .full_o           (full_o),
    .almost_full_o    (almost_full_o),
    .overflow_o       (overflow_o),
    .overflow_clr_i   (overflow_clr_i)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         modelLevel = 0;
  bit         modelOvf = 1'b0;
  bit         prevDrop = 1'b0;
  bit         doPush, doPop;
  logic [9:0] sbQ[$];
  logic [9:0] expEntry;

  function automatic logic [1:0] expTag(input logic stopErr, input logic parErr);
`ifdef UART_RX_FIFO_ERR_TAG_EN
    return {stopErr, parErr};
`else
    return 2'b00;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain occupancy count plus an ordered queue of expected head entries.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelLevel = 0;
      modelOvf   = 1'b0;
      prevDrop   = 1'b0;
      sbQ.delete();
    end else begin
      doPush = saxis_tvalid_i && (modelLevel < DEPTH);
      doPop  = maxis_tready_i && (modelLevel > 0);
      if (flush_i) begin
        modelLevel = 0;
        sbQ.delete();
      end else begin
        if (doPush) begin
          modelLevel++;
          sbQ.push_back({expTag(err_stop_i, err_rx_i), saxis_data_i});
        end
        if (doPop) modelLevel--;
      end
      if (err_rx_dropped_i && !prevDrop) modelOvf = 1'b1;
      else if (overflow_clr_i) modelOvf = 1'b0;
      prevDrop = err_rx_dropped_i;
    end
  end

  // Status outputs checked every cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("level", level_o, modelLevel);
      checkOutput("tvalid", maxis_tvalid_o, modelLevel > 0);
      checkOutput("empty", empty_o, modelLevel == 0);
      checkOutput("full", full_o, modelLevel == DEPTH);
      checkOutput("tready", saxis_tready_o, modelLevel < DEPTH);
      checkOutput("almost_full", almost_full_o, modelLevel >= int'(af_thr_i));
      checkOutput("overflow", overflow_o, modelOvf);
    end
  end

  // Scoreboard monitor: every accepted head is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && maxis_tvalid_o && maxis_tready_i) begin
      if (sbQ.size() == 0) begin
        checkOutput("head_underrun", {24'h0, maxis_data_o}, 32'hFFFF_FFFF);
      end else begin
        expEntry = sbQ.pop_front();
        checkOutput("head_data", maxis_data_o, expEntry[7:0]);
        checkOutput("head_tuser", maxis_tuser_o, expEntry[9:8]);
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
    saxis_tvalid_i = v;
    saxis_data_i   = d;
    maxis_tready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_level", level_o, 0);
    checkOutput("rst_tvalid", maxis_tvalid_o, 0);
    checkOutput("rst_data", maxis_data_o, 0);
    checkOutput("rst_tuser", maxis_tuser_o, 0);
    checkOutput("rst_empty", empty_o, 1);
    checkOutput("rst_full", full_o, 0);
    checkOutput("rst_overflow", overflow_o, 0);
    checkOutput("rst_tready", saxis_tready_o, 1);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  task automatic randomRun(input int cycles, input int pv, input int pr);
    for (int i = 0; i < cycles; i++) begin
      flush_i        = ($urandom_range(0, 99) < 2);
      err_rx_i       = $urandom_range(0, 1) == 1;
      err_stop_i     = $urandom_range(0, 1) == 1;
      overflow_clr_i = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 8) err_rx_dropped_i = ~err_rx_dropped_i;
      if ($urandom_range(0, 99) < 5) af_thr_i = LVL_W'($urandom_range(0, (1 << LVL_W) - 1));
      applyStimulus($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr);
    end
    flush_i = 1'b0;
    overflow_clr_i = 1'b0;
    err_rx_dropped_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    rst = 1'b0;

    $display("[TB] single byte latency");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    drain(2);

    $display("[TB] fill to full, hold 17th, drain in order");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    repeat (3) applyStimulus(1'b1, 8'h10, 1'b0);
    repeat (2) applyStimulus(1'b1, 8'h10, 1'b1);
    drain(DEPTH + 2);

    $display("[TB] steady push+pop at level 8");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    drain(10);

    $display("[TB] flush with coincident push");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    flush_i = 1'b1;
    applyStimulus(1'b1, 8'h33, 1'b0);
    flush_i = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    drain(3);

    $display("[TB] overflow set/clear");
    err_rx_dropped_i = 1'b1;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    err_rx_dropped_i = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    overflow_clr_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    overflow_clr_i = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    err_rx_dropped_i = 1'b1;
    overflow_clr_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    overflow_clr_i = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    overflow_clr_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    overflow_clr_i = 1'b0;
    err_rx_dropped_i = 1'b0;

    $display("[TB] error tag capture");
    err_rx_i = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0);
    err_rx_i = 1'b0;
    err_stop_i = 1'b1;
    applyStimulus(1'b1, 8'hC3, 1'b0);
    err_stop_i = 1'b0;
    drain(3);

    $display("[TB] almost-full thresholds");
    af_thr_i = '0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    af_thr_i = LVL_W'(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    af_thr_i = LVL_W'(DEPTH);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain(DEPTH + 1);

    $display("[TB] randomized traffic");
    randomRun(500, 70, 30);
    randomRun(500, 50, 50);
    randomRun(500, 30, 80);

    $display("[TB] asynchronous reset mid-transfer");
    err_rx_dropped_i = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    err_rx_dropped_i = 1'b0;
    saxis_tvalid_i = 1'b1;
    rst = 1'b1;
    #1;
    checkResetState();
    @(posedge clk);
    #1;
    saxis_tvalid_i = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    randomRun(200, 60, 60);
    drain(DEPTH + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
